// File: rtl/wrr_pkg.sv
// -----------------------------------------------------------------------------
// wrr_pkg
// Shared definitions for the weighted round-robin arbiter:
//   - state_t : FSM state encoding visible on the arbiter's state port
//   - act_t   : per-cycle grant action chosen by the FSM
//   - wrr_clog2 : ceiling log2, used to check the grant-index width
//   - norm_weight : effective burst length (a weight of 0 behaves as 1)
// -----------------------------------------------------------------------------
package wrr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT  = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // What the grant datapath does on the next edge.
  typedef enum logic [1:0] {
    ACT_KEEP = 2'b00,  // freeze owner and burst count
    ACT_HOLD = 2'b01,  // same owner, one more cycle of its burst
    ACT_NEW  = 2'b10,  // hand the grant to the picker's winner
    ACT_IDLE = 2'b11   // nobody requesting, drop the grant
  } act_t;

  function automatic int wrr_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned norm_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/wrr_arbiter_rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority picker. The search starts at ptr+1 and wraps
// modulo N; the first index with req high wins.
// Ports:
//   req     [N-1:0]   request vector
//   ptr     [IDW-1:0] index of the previous winner (lowest priority)
//   win_oh  [N-1:0]   one-hot winner, zero when nobody requests
//   win_idx [IDW-1:0] binary winner index, zero when nobody requests
//   any               at least one request is high
// -----------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win_oh,
  output logic [IDW-1:0] win_idx,
  output logic           any
);

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IDW'(s);
  endfunction

  logic [IDW-1:0] cand;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = wrap_idx(ptr, k);
      if (!any && req[cand]) begin
        any          = 1'b1;
        win_idx      = cand;
        win_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_arbiter
// Weighted round-robin arbiter sharing one resource between N requesters.
// The owner keeps the grant for up to its latched weight of consecutive cycles
// (weight 0 acts as 1), then rotation moves on. A requester dropping its
// request hands over on the same edge, so there is no dead cycle.
//
// Optional feature macro: WRR_LOCK_EN
//   When defined, adds input 'lock'. A requesting owner with lock high is held
//   indefinitely in LOCKED (burst count frozen); on exit the burst counts as
//   exhausted. Without the macro, LOCKED is unreachable.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   lock       (WRR_LOCK_EN only) hold the current owner
//   req        [N-1:0] level-sensitive requests
//   weight     [N*WW-1:0] burst limits, field i = weight[i*WW +: WW]
//   gnt        [N-1:0] registered one-hot grant, zero when idle
//   gnt_id     [IDW-1:0] index of the current/last owner
//   gnt_valid  registered |gnt
//   state      [1:0] FSM state (00 IDLE, 01 GRANT, 10 LOCKED)
// -----------------------------------------------------------------------------
module wrr_arbiter
  import wrr_pkg::*;
#(
  parameter int N   = 3,
  parameter int WW  = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef WRR_LOCK_EN
  input  logic            lock,
`endif
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic [1:0]      state
);

  if (IDW < wrr_clog2(N)) begin : g_bad_idw
    $error("wrr_arbiter: IDW too narrow for N requesters");
  end

  state_t         state_q, state_n;
  act_t           action;
  logic [N-1:0]   gnt_q, gnt_n;
  logic [IDW-1:0] id_q, id_n;
  logic [IDW-1:0] ptr_q, ptr_n;
  logic [WW-1:0]  cnt_q, cnt_n;
  logic [WW-1:0]  w_lat_q, w_lat_n;
  logic           valid_q;

  logic [N-1:0]   win_oh;
  logic [IDW-1:0] win_idx;
  logic           any_req;
  logic           req_own;
  logic [WW-1:0]  wt [N];

  for (genvar i = 0; i < N; i++) begin : g_wt
    assign wt[i] = weight[i*WW +: WW];
  end

  rr_priority_pick #(.N(N), .IDW(IDW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any_req)
  );

  // Owner's request; only meaningful outside IDLE.
  assign req_own = req[id_q];

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= IDW'(N - 1);
      cnt_q   <= '0;
      w_lat_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      id_q    <= id_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      w_lat_q <= w_lat_n;
      valid_q <= |gnt_n;
    end
  end

  // Next-state logic: picks the state and the grant action.
  always_comb begin
    state_n = state_q;
    action  = ACT_KEEP;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_n = ST_GRANT;
          action  = ACT_NEW;
        end
      end
      ST_GRANT: begin
        if (!req_own) begin
          // Owner left: any remaining request is necessarily someone else.
          state_n = any_req ? ST_GRANT : ST_IDLE;
          action  = any_req ? ACT_NEW : ACT_IDLE;
`ifdef WRR_LOCK_EN
        end else if (lock) begin
          state_n = ST_LOCKED;
          action  = ACT_KEEP;
`endif
        end else if (cnt_q < w_lat_q) begin
          action = ACT_HOLD;
        end else begin
          // Burst used up; the picker re-selects the owner if it is alone.
          action = ACT_NEW;
        end
      end
`ifdef WRR_LOCK_EN
      ST_LOCKED: begin
        if (!req_own) begin
          state_n = any_req ? ST_GRANT : ST_IDLE;
          action  = any_req ? ACT_NEW : ACT_IDLE;
        end else if (!lock) begin
          state_n = ST_GRANT;
          action  = ACT_NEW;
        end
      end
`endif
      default: begin
        state_n = ST_IDLE;
        action  = ACT_IDLE;
      end
    endcase
  end

  // Output/datapath logic: next register values for the chosen action.
  always_comb begin
    gnt_n   = gnt_q;
    id_n    = id_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    w_lat_n = w_lat_q;
    unique case (action)
      ACT_NEW: begin
        gnt_n   = win_oh;
        id_n    = win_idx;
        ptr_n   = win_idx;
        cnt_n   = WW'(1);
        w_lat_n = WW'(norm_weight(32'(wt[win_idx])));
      end
      ACT_HOLD: cnt_n = cnt_q + WW'(1);
      ACT_IDLE: begin
        gnt_n = '0;
        cnt_n = '0;
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wrr_arbiter
// Self-checking bench for wrr_arbiter: directed scenarios followed by random
// requests and weights, all compared every cycle against a behavioural model
// that tracks owner / cycles used / burst limit as plain integers.
// -----------------------------------------------------------------------------
module tb_wrr_arbiter;

  localparam int N   = 3;
  localparam int WW  = 4;
  localparam int IDW = 2;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic            lock   = 1'b0;
  logic [N-1:0]    req    = '0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]    gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_valid;
  logic [1:0]      state;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_owner;   // -1 when idle
  int m_last;    // previous winner; search starts after it
  int m_id;      // last granted index
  int m_used;    // cycles of the current burst consumed
  int m_limit;   // effective weight latched at grant start
  bit m_locked;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WW(WW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef WRR_LOCK_EN
    .lock      (lock),
`endif
    .req       (req),
    .weight    (weight),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .state     (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int field_w(input int i);
    int w;
    w = int'(weight[i*WW +: WW]);
    return (w == 0) ? 1 : w;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_last   = N - 1;
    m_id     = 0;
    m_used   = 0;
    m_limit  = 1;
    m_locked = 1'b0;
  endtask

  task automatic model_grant(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (r[j]) begin
        m_owner = j;
        m_last  = j;
        m_id    = j;
        m_used  = 1;
        m_limit = field_w(j);
        return;
      end
    end
  endtask

  // One clock edge of the arbitration rules, using the sampled inputs.
  task automatic model_step();
    logic [N-1:0] r;
    r = req;
    if (m_owner < 0) begin
      if (|r) model_grant(r);
    end else if (!r[m_owner]) begin
      m_locked = 1'b0;
      if (|r) model_grant(r);
      else m_owner = -1;
`ifdef WRR_LOCK_EN
    end else if (lock) begin
      m_locked = 1'b1;
`endif
    end else if (m_locked) begin
      m_locked = 1'b0;
      model_grant(r);
    end else if (m_used < m_limit) begin
      m_used++;
    end else begin
      model_grant(r);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    int es;
    eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    es = (m_owner < 0) ? 0 : (m_locked ? 2 : 1);
    check({tag, ".gnt"},       32'(gnt),       32'(eg));
    check({tag, ".gnt_id"},    32'(gnt_id),    32'(m_id));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
    check({tag, ".state"},     32'(state),     32'(es));
  endtask

  // Advance one edge, update the model, sample 1 ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    model_reset();
    check("reset.gnt",       32'(gnt),       32'(0));
    check("reset.gnt_valid", 32'(gnt_valid), 32'(0));
    check("reset.gnt_id",    32'(gnt_id),    32'(0));
    check("reset.state",     32'(state),     32'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [N*WW-1:0] pack_w(input int w0, input int w1, input int w2);
    return {WW'(w2), WW'(w1), WW'(w0)};
  endfunction

  logic [N-1:0] seq1 [6];

  initial begin
    model_reset();
    seq1 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    // 1: all weights 1, everyone requesting -> plain rotation from requester 0.
    weight = pack_w(1, 1, 1);
    req    = 3'b111;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick("t1");
      check("t1.seq", 32'(gnt), 32'(seq1[i]));
    end

    // 2: weights 2/1/3, bursts of matching length.
    do_reset();
    weight = pack_w(2, 1, 3);
    req    = 3'b111;
    for (int i = 0; i < 12; i++) tick("t2");

    // 3: requester 1 silent, then everyone drops.
    do_reset();
    weight = pack_w(1, 1, 1);
    req    = 3'b101;
    for (int i = 0; i < 6; i++) begin
      tick("t3");
      check("t3.no_gnt1", 32'(gnt[1]), 32'(0));
    end
    req = 3'b000;
    tick("t3.idle");
    check("t3.idle_state", 32'(state), 32'(0));

    // 4: owner 0 drops after two granted cycles -> immediate handover to 1.
    do_reset();
    weight = pack_w(4, 1, 1);
    req    = 3'b111;
    tick("t4");
    tick("t4");
    req = 3'b110;
    tick("t4.handover");
    check("t4.handover_gnt", 32'(gnt), 32'(3'b010));

    // 5: lone requester re-granted continuously; weight 0 acts as 1.
    do_reset();
    weight = pack_w(1, 2, 1);
    req    = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick("t5");
      check("t5.hold", 32'(gnt), 32'(3'b010));
    end
    do_reset();
    weight = '0;
    req    = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick("t5.w0");
      check("t5.w0_seq", 32'(gnt), 32'(seq1[i]));
    end

    // 6: async reset in the middle of requester 2's burst.
    do_reset();
    weight = pack_w(1, 1, 15);
    req    = 3'b100;
    for (int i = 0; i < 3; i++) tick("t6");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6.async_gnt",   32'(gnt),       32'(0));
    check("t6.async_valid", 32'(gnt_valid), 32'(0));
    check("t6.async_state", 32'(state),     32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req   = 3'b111;
    tick("t6.restart");
    check("t6.first_gnt", 32'(gnt), 32'(3'b001));

`ifdef WRR_LOCK_EN
    // Lock under owner 1 holds it indefinitely.
    do_reset();
    weight = pack_w(1, 1, 1);
    req    = 3'b111;
    tick("lk");
    tick("lk");
    lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick("lk.hold");
      check("lk.gnt",   32'(gnt),   32'(3'b010));
      check("lk.state", 32'(state), 32'(2));
    end
    lock = 1'b0;
    tick("lk.exit");
`endif

    // Random phase: requests every cycle, weights (including 0) now and then.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req = N'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      if (i % 17 == 0) weight = (N*WW)'($urandom);
`ifdef WRR_LOCK_EN
      lock = ($urandom_range(0, 7) == 0);
`endif
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
